// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared types and constants for the min:sec countdown timer controller.
package countdown_timer_ctrl_pkg;

  localparam int unsigned TIME_W = 6;

  localparam logic [TIME_W-1:0] MAX_SEC = 6'd59;
  localparam logic [TIME_W-1:0] MAX_MIN = 6'd59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] v,
                                                   input logic [TIME_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/countdown_timer_ctrl_tick_prescaler.sv
// Divides Clk down to a one-cycle tick strobe every TICK_DIV enabled cycles.
module countdown_timer_ctrl_tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic Zero,
  output logic Tick
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Combinational strobe: the controller acts on it at the same edge the count wraps.
  assign Tick = Run && !Zero && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (Zero) begin
      cnt_d = '0;
    end else if (Tick) begin
      cnt_d = '0;
    end else if (Run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer FSM and min:sec down-counter, paced by the tick prescaler.
module countdown_timer_ctrl
  import countdown_timer_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              Load,
  input  logic              Go,
  input  logic [TIME_W-1:0] SetMin,
  input  logic [TIME_W-1:0] SetSec,
  output logic [TIME_W-1:0] Min,
  output logic [TIME_W-1:0] Sec,
  output logic              Running,
  output logic              Done,
  output logic              DonePulse,
  output logic              Tick
);

  state_e            state_q, state_d;
  logic [TIME_W-1:0] min_q, min_d, sec_q, sec_d;
  logic              running_q, done_q, done_pulse_q, tick_q;
  logic              presc_tick, presc_zero;

  // Prescaler parks at zero whenever the countdown is not live or is being reloaded.
  assign presc_zero = Clear || Load || (state_q == IDLE) || (state_q == DONE);

  countdown_timer_ctrl_tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .Clk   (Clk),
    .Reset (Reset),
    .Run   (state_q == RUN),
    .Zero  (presc_zero),
    .Tick  (presc_tick)
  );

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    if (Clear) begin
      min_d   = '0;
      sec_d   = '0;
      state_d = IDLE;
    end else if (Load) begin
      min_d   = clamp_time(SetMin, MAX_MIN);
      sec_d   = clamp_time(SetSec, MAX_SEC);
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Go && ((min_q != '0) || (sec_q != '0))) state_d = RUN;
        end
        RUN: begin
          if (presc_tick) begin
            if (sec_q != '0) begin
              sec_d = sec_q - 1'b1;
            end else begin
              sec_d = MAX_SEC;
              min_d = min_q - 1'b1;
            end
            // Reaching 00:00 takes precedence over a coincident pause request.
            if ((min_d == '0) && (sec_d == '0)) state_d = DONE;
            else if (Go) state_d = PAUSE;
          end else if (Go) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (Go) state_d = RUN;
        end
        DONE: begin
          min_d = '0;
          sec_d = '0;
          if (Go) state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      min_q        <= '0;
      sec_q        <= '0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      running_q    <= (state_d == RUN);
      done_q       <= (state_d == DONE);
      done_pulse_q <= (state_d == DONE) && (state_q != DONE);
      tick_q       <= presc_tick;
    end
  end

  assign Min       = min_q;
  assign Sec       = sec_q;
  assign Running   = running_q;
  assign Done      = done_q;
  assign DonePulse = done_pulse_q;
  assign Tick      = tick_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Randomized and directed checks of countdown_timer_ctrl against a seconds-based model.
module tb_countdown_timer_ctrl;

  localparam int unsigned TickDiv = 4;
  localparam int MIdle = 0, MRun = 1, MPause = 2, MDone = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Clear = 1'b0, Load = 1'b0, Go = 1'b0;
  logic [5:0] SetMin = '0, SetSec = '0;
  logic [5:0] Min, Sec;
  logic       Running, Done, DonePulse, Tick;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: remaining time in seconds, mode, and cycles elapsed in the current second.
  int m_rem   = 0;
  int m_mode  = MIdle;
  int m_phase = 0;
  bit m_pulse = 1'b0;
  bit m_tick  = 1'b0;

  countdown_timer_ctrl #(
    .TICK_DIV (TickDiv),
    .CNT_W    (3)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Clear     (Clear),
    .Load      (Load),
    .Go        (Go),
    .SetMin    (SetMin),
    .SetSec    (SetSec),
    .Min       (Min),
    .Sec       (Sec),
    .Running   (Running),
    .Done      (Done),
    .DonePulse (DonePulse),
    .Tick      (Tick)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_mode = MIdle; m_phase = 0; m_pulse = 1'b0; m_tick = 1'b0;
  endtask

  task automatic model_edge(input bit c, input bit l, input bit g,
                            input int sm, input int ss);
    m_tick  = (m_mode == MRun) && !c && !l && (m_phase == int'(TickDiv) - 1);
    m_pulse = 1'b0;
    if (c) begin
      m_rem = 0; m_mode = MIdle; m_phase = 0;
    end else if (l) begin
      m_rem = ((sm > 59) ? 59 : sm) * 60 + ((ss > 59) ? 59 : ss);
      m_mode = MIdle; m_phase = 0;
    end else if (m_mode == MIdle) begin
      if (g && m_rem > 0) m_mode = MRun;
    end else if (m_mode == MRun) begin
      m_phase = (m_phase + 1) % int'(TickDiv);
      if (m_tick) m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_mode = MDone; m_pulse = 1'b1;
      end else if (g) begin
        m_mode = MPause;
      end
    end else if (m_mode == MPause) begin
      if (g) m_mode = MRun;
    end else begin
      if (g) m_mode = MIdle;
    end
  endtask

  task automatic compare_all();
    check("min",       32'(Min),       32'(m_rem / 60));
    check("sec",       32'(Sec),       32'(m_rem % 60));
    check("running",   32'(Running),   32'(m_mode == MRun));
    check("done",      32'(Done),      32'(m_mode == MDone));
    check("donepulse", 32'(DonePulse), 32'(m_pulse));
    check("tick",      32'(Tick),      32'(m_tick));
  endtask

  task automatic step(input bit c, input bit l, input bit g,
                      input logic [5:0] sm, input logic [5:0] ss);
    Clear = c; Load = l; Go = g; SetMin = sm; SetSec = ss;
    @(posedge Clk);
    model_edge(c, l, g, int'(sm), int'(ss));
    #1;
    Clear = 1'b0; Load = 1'b0; Go = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
  endtask

  initial begin
    // Power-on reset
    #2;
    check("rst_min", 32'(Min), 32'd0);
    check("rst_running", 32'(Running), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    compare_all();

    // 00:02 countdown to expiry
    step(1'b0, 1'b1, 1'b0, 6'd0, 6'd2);
    step(1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    idle(3);
    check("t1_sec_hold", 32'(Sec), 32'd2);
    idle(1);
    check("t1_sec_1", 32'(Sec), 32'd1);
    idle(4);
    check("t1_sec_0", 32'(Sec), 32'd0);
    check("t1_done", 32'(Done), 32'd1);
    check("t1_pulse", 32'(DonePulse), 32'd1);
    check("t1_running", 32'(Running), 32'd0);
    idle(1);
    check("t1_pulse_once", 32'(DonePulse), 32'd0);
    step(1'b0, 1'b0, 1'b1, 6'd0, 6'd0);

    // 01:00 borrows into minutes
    step(1'b0, 1'b1, 1'b0, 6'd1, 6'd0);
    step(1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    idle(4);
    check("t2_min", 32'(Min), 32'd0);
    check("t2_sec", 32'(Sec), 32'd59);
    check("t2_done", 32'(Done), 32'd0);

    // Pause preserves the partial second
    step(1'b0, 1'b1, 1'b0, 6'd0, 6'd5);
    step(1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    idle(1);
    step(1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    idle(10);
    check("t3_pause_sec", 32'(Sec), 32'd5);
    step(1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    idle(1);
    check("t3_resume_hold", 32'(Sec), 32'd5);
    idle(1);
    check("t3_resume_sec", 32'(Sec), 32'd4);

    // Saturating load, then Go at 00:00 does nothing
    step(1'b0, 1'b1, 1'b0, 6'd63, 6'd60);
    check("t4_min_sat", 32'(Min), 32'd59);
    check("t4_sec_sat", 32'(Sec), 32'd59);
    step(1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
    step(1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    check("t4_go_zero", 32'(Running), 32'd0);

    // Load beats Go during RUN
    step(1'b0, 1'b1, 1'b0, 6'd0, 6'd5);
    step(1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    idle(2);
    step(1'b0, 1'b1, 1'b1, 6'd2, 6'd7);
    check("t5_running", 32'(Running), 32'd0);
    check("t5_min", 32'(Min), 32'd2);
    check("t5_sec", 32'(Sec), 32'd7);

    // Go coincident with the final tick: DONE wins over PAUSE
    step(1'b0, 1'b1, 1'b0, 6'd0, 6'd2);
    step(1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    idle(7);
    step(1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    check("t6_done", 32'(Done), 32'd1);
    check("t6_pulse", 32'(DonePulse), 32'd1);
    check("t6_running", 32'(Running), 32'd0);

    // Asynchronous reset mid-run at 00:03
    step(1'b0, 1'b1, 1'b0, 6'd0, 6'd3);
    step(1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    idle(2);
    #2 Reset = 1'b1;
    #1;
    check("t7_async_sec", 32'(Sec), 32'd0);
    check("t7_async_running", 32'(Running), 32'd0);
    check("t7_async_tick", 32'(Tick), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
      check("t7_no_tick", 32'(Tick), 32'd0);
    end

    // Randomized command stream
    for (int i = 0; i < 600; i++) begin
      automatic int  r  = int'($urandom_range(0, 99));
      automatic bit  c  = (r < 2);
      automatic bit  l  = (r >= 2 && r < 8);
      automatic bit  g  = (r >= 8 && r < 20) || ($urandom_range(0, 99) < 3);
      automatic logic [5:0] sm = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
      automatic logic [5:0] ss = 6'($urandom_range(0, 63));
      step(c, l, g, sm, ss);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule
